isr_check: RTL and testbench

Sequential checker for integer-square-root results: it takes a 64-bit operand `value` and a 32-bit candidate `result`, squares the candidate with an iterative shift-add multiplier, and decides whether `result == floor(sqrt(value))`. It is the inverse-direction companion to the ISR datapath. Benches and the self-test wrapper use it as a hardware oracle, so ISR outputs can be checked without real-valued `$sqrt`.

---
 rtl/isr_check.sv | 91 +++++++++
 tb/tb_isr_check.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/isr_check.sv
// Integer-square-root oracle: squares a candidate root with a 32-step
// shift-add multiplier and reports whether it equals floor(sqrt(value)).
module isr_check (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [63:0] value,
    input  logic [31:0] result,
    output logic        busy,
    output logic        done,
    output logic [63:0] square,
    output logic        correct
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] MULT  = 2'd1;
    localparam logic [1:0] CHECK = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]  state;
    logic [63:0] v_q;
    logic [31:0] r_q;
    logic [63:0] m_q;
    logic [31:0] q_q;
    logic [63:0] acc;
    logic [5:0]  count;

    logic        accept;
    logic [63:0] acc_next;
    logic [63:0] diff;
    logic [63:0] limit;
    logic        in_range;

    assign accept   = start && (state == IDLE || state == DONE);
    assign acc_next = q_q[0] ? acc + m_q : acc;

    // V < A + 2R + 1 rewritten so nothing needs a 65th bit
    assign diff     = v_q - acc;
    assign limit    = {31'b0, r_q, 1'b0};
    assign in_range = (v_q >= acc) && (diff <= limit);

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            v_q     <= '0;
            r_q     <= '0;
            m_q     <= '0;
            q_q     <= '0;
            acc     <= '0;
            count   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            square  <= '0;
            correct <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        v_q   <= value;
                        r_q   <= result;
                        m_q   <= {32'b0, result};
                        q_q   <= result;
                        acc   <= '0;
                        count <= '0;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        state <= MULT;
                    end
                end
                MULT: begin
                    acc   <= acc_next;
                    m_q   <= m_q << 1;
                    q_q   <= q_q >> 1;
                    count <= count + 6'd1;
                    if (count == 6'd31) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    square  <= acc;
                    correct <= in_range;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_isr_check.sv
// Scoreboard bench for isr_check: expected square/verdict queued at start,
// compared when done rises 34 edges later.
module tb_isr_check;

    logic        clock;
    logic        reset;
    logic        start;
    logic [63:0] value;
    logic [31:0] result;
    logic        busy;
    logic        done;
    logic [63:0] square;
    logic        correct;

    typedef struct {
        logic [63:0] sq;
        logic        ok;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [63:0] prev_sq;

    isr_check dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .value   (value),
        .result  (result),
        .busy    (busy),
        .done    (done),
        .square  (square),
        .correct (correct)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // glitch_at: edge index carrying a spurious start; abort_at: reset edge
    task automatic run(input logic [63:0] v, input logic [31:0] r,
                       input int glitch_at, input int abort_at);
        exp_t e;
        logic [127:0] s;
        logic [127:0] nx;
        logic [127:0] vv;
        s  = {96'b0, r} * {96'b0, r};
        nx = ({96'b0, r} + 128'd1) * ({96'b0, r} + 128'd1);
        vv = {64'b0, v};
        e.sq = s[63:0];
        e.ok = (s <= vv) && (vv < nx);
        sb.push_back(e);
        @(negedge clock);
        value  = v;
        result = r;
        start  = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        check("accept_busy", {63'b0, busy}, 64'd1);
        check("accept_done", {63'b0, done}, 64'd0);
        check("hold_square", square, prev_sq);
        for (int i = 1; i <= 33; i++) begin
            if (i == glitch_at) begin
                value  = ~v;
                result = r + 32'd3;
                start  = 1'b1;
            end
            if (i == abort_at) reset = 1'b1;
            @(posedge clock);
            #1;
            start = 1'b0;
            if (i == abort_at) begin
                reset = 1'b0;
                check("abort_busy", {63'b0, busy}, 64'd0);
                check("abort_done", {63'b0, done}, 64'd0);
                check("abort_square", square, 64'd0);
                check("abort_correct", {63'b0, correct}, 64'd0);
                void'(sb.pop_front());
                prev_sq = '0;
                return;
            end
            if (i < 33) begin
                if (busy !== 1'b1 || done !== 1'b0) begin
                    check("run_busy", {63'b0, busy}, 64'd1);
                    check("run_done", {63'b0, done}, 64'd0);
                end
            end else begin
                check("end_busy", {63'b0, busy}, 64'd0);
                check("end_done", {63'b0, done}, 64'd1);
            end
        end
        e = sb.pop_front();
        check("square", square, e.sq);
        check("correct", {63'b0, correct}, {63'b0, e.ok});
        prev_sq = e.sq;
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        value   = '0;
        result  = '0;
        prev_sq = '0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        check("rst_square", square, 64'd0);
        check("rst_correct", {63'b0, correct}, 64'd0);

        run(64'd24, 32'd4, 0, 0);
        run(64'd24, 32'd5, 0, 0);
        run(64'd65536, 32'd255, 0, 0);
        run(64'd65536, 32'd256, 0, 0);
        run(64'd0, 32'd0, 0, 0);
        run(64'd1, 32'd0, 0, 0);
        run(64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        run(64'hFFFF_FFFF_FFFF_FFFE, 32'hFFFF_FFFF, 0, 0);
        run(64'd5000, 32'd70, 0, 10);
        run(64'd1001, 32'd31, 0, 0);
        run(64'd99, 32'd9, 5, 0);
        run(64'd100, 32'd10, 0, 0);
        for (int k = 0; k < 6; k++) begin
            logic [31:0] rr;
            logic [63:0] vv;
            rr = $urandom;
            vv = {$urandom, $urandom};
            if (k[0]) vv = {32'b0, rr} * {32'b0, rr} + {32'b0, rr};
            run(vv, rr, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
